// File: rtl/pc_sequencer.sv
// Registered program-counter sequencer: BOOT/RUN control, sequential increment, redirect with
// alignment trap, and fetch counter. Define PC_RVC_EN for 16-bit compressed-instruction support.
module pc_sequencer #(
   parameter int unsigned     XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
   parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
   parameter int unsigned     CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             stall,
   input  logic             redirect,
   input  logic [XLEN-1:0]  redirect_target,
   input  logic             is_compressed,
   output logic [XLEN-1:0]  PC,
   output logic [XLEN-1:0]  PCPlusN,
   output logic             misaligned,
   output logic [CNT_W-1:0] fetch_count
);

   typedef enum logic [0:0] {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              misaligned_q, misaligned_d;
   logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;
   logic [XLEN-1:0]   inc_s;

   // A target is legal only on an instruction boundary of the narrowest supported encoding.
   function automatic logic target_misaligned(input logic [XLEN-1:0] target);
`ifdef PC_RVC_EN
      return target[0];
`else
      return |target[1:0];
`endif
   endfunction

   // Sequential increment size for the instruction at the current PC.
   always_comb begin
`ifdef PC_RVC_EN
      if (is_compressed) begin
         inc_s = XLEN'(3'd2);
      end else begin
         inc_s = XLEN'(3'd4);
      end
`else
      inc_s = XLEN'(3'd4);
`endif
   end

   assign PCPlusN = pc_q + inc_s;

   // Next-state logic: stall beats redirect beats sequential advance; BOOT is one idle cycle.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      misaligned_d  = 1'b0;
      fetch_count_d = fetch_count_q;
      case (state_q)
         ST_BOOT: begin
            state_d = ST_RUN;
         end
         ST_RUN: begin
            if (stall) begin
               pc_d = pc_q;
            end else if (redirect) begin
               fetch_count_d = fetch_count_q + CNT_W'(1'b1);
               if (target_misaligned(redirect_target)) begin
                  pc_d         = TRAP_VECTOR;
                  misaligned_d = 1'b1;
               end else begin
                  pc_d = redirect_target;
               end
            end else begin
               pc_d          = PCPlusN;
               fetch_count_d = fetch_count_q + CNT_W'(1'b1);
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_BOOT;
         pc_q          <= RESET_VECTOR;
         misaligned_q  <= 1'b0;
         fetch_count_q <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         misaligned_q  <= misaligned_d;
         fetch_count_q <= fetch_count_d;
      end
   end

   assign PC          = pc_q;
   assign misaligned  = misaligned_q;
   assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed scenarios plus random traffic against a reference
// model; expected state is queued per cycle and checked by an independent monitor.
module tb_pc_sequencer;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 8;
   localparam logic [31:0] RV    = 32'h0000_0000;
   localparam logic [31:0] TV    = 32'h0000_0100;
`ifdef PC_RVC_EN
   localparam int unsigned ALIGN = 2;
`else
   localparam int unsigned ALIGN = 4;
`endif

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic             stall = 1'b0;
   logic             redirect = 1'b0;
   logic [31:0]      redirect_target = 32'h0;
   logic             is_compressed = 1'b0;
   logic [31:0]      pc_o;
   logic [31:0]      pcplusn_o;
   logic             mis_o;
   logic [CNT_W-1:0] cnt_o;

   typedef struct {
      logic [31:0]      pc;
      logic             mis;
      logic [CNT_W-1:0] cnt;
      int               tag;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   int   tag   = 0;

   // reference model state
   logic [31:0]      m_pc = RV;
   logic [CNT_W-1:0] m_cnt = '0;
   logic             m_mis = 1'b0;
   int               m_since_reset = 0;

   pc_sequencer #(.XLEN(XLEN), .RESET_VECTOR(RV), .TRAP_VECTOR(TV), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
      .redirect_target(redirect_target), .is_compressed(is_compressed),
      .PC(pc_o), .PCPlusN(pcplusn_o), .misaligned(mis_o), .fetch_count(cnt_o)
   );

   always #5 clk = ~clk;

   function automatic int unsigned step_size(input logic comp);
`ifdef PC_RVC_EN
      return comp ? 2 : 4;
`else
      return 4;
`endif
   endfunction

   // Drive one cycle of inputs, advance the model, queue what PC etc. must show after the edge.
   task automatic cyc(input logic r, input logic st, input logic rd, input logic [31:0] tgt,
                      input logic comp);
      exp_t e;
      @(negedge clk);
      reset = r; stall = st; redirect = rd; redirect_target = tgt; is_compressed = comp;
      m_mis = 1'b0;
      if (r) begin
         m_pc = RV; m_cnt = '0; m_since_reset = 0;
      end else begin
         m_since_reset++;
         if (m_since_reset == 1) begin
            // first cycle out of reset: nothing moves
         end else if (st) begin
            // held
         end else if (rd) begin
            m_cnt++;
            if ((tgt % ALIGN) != 0) begin
               m_pc = TV; m_mis = 1'b1;
            end else begin
               m_pc = tgt;
            end
         end else begin
            m_cnt++;
            m_pc = m_pc + step_size(comp);
         end
      end
      e.pc = m_pc; e.mis = m_mis; e.cnt = m_cnt; e.tag = tag;
      exp_q.push_back(e);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   // Monitor: compare DUT outputs against the oldest queued expectation after every edge.
   always @(posedge clk) begin
      exp_t e;
      logic [31:0] exp_pn;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         exp_pn = e.pc + step_size(is_compressed);
         n_cmp += 4;
         if (pc_o !== e.pc) begin
            n_err++; $display("FAIL pc tag=%0d got=%h want=%h t=%0t", e.tag, pc_o, e.pc, $time);
         end
         if (pcplusn_o !== exp_pn) begin
            n_err++; $display("FAIL pcplusn tag=%0d got=%h want=%h", e.tag, pcplusn_o, exp_pn);
         end
         if (mis_o !== e.mis) begin
            n_err++; $display("FAIL misaligned tag=%0d got=%b want=%b", e.tag, mis_o, e.mis);
         end
         if (cnt_o !== e.cnt) begin
            n_err++; $display("FAIL fetch_count tag=%0d got=%h want=%h", e.tag, cnt_o, e.cnt);
         end
      end
   end

   initial begin
      logic [31:0] t;
      int waited;
      // T1: reset, BOOT, then sequential fetch
      tag = 1;
      cyc(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 32'h0000_0300, 1'b0);
      run(5);
      // T2: redirect to aligned target
      tag = 2;
      cyc(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0);
      run(2);
      // T3: 2-byte and 1-byte offset targets
      tag = 3;
      cyc(1'b0, 1'b0, 1'b1, 32'h0000_0202, 1'b0);
      run(2);
      cyc(1'b0, 1'b0, 1'b1, 32'h0000_0203, 1'b0);
      run(2);
      // T4: stall together with redirect holds PC
      tag = 4;
      cyc(1'b0, 1'b0, 1'b1, 32'h0000_0040, 1'b0);
      for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 32'h0000_0800, 1'b0);
      run(2);
      // T5: PC wrap at top of address space, then counter wrap
      tag = 5;
      cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
      run(3);
      run(260);
      // T6: reset same cycle as redirect; BOOT ignores redirect; compressed stepping
      tag = 6;
      cyc(1'b1, 1'b0, 1'b1, 32'h0000_0300, 1'b0);
      cyc(1'b0, 1'b0, 1'b1, 32'h0000_0300, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      // Random traffic
      tag = 7;
      for (int i = 0; i < 3000; i++) begin
         t = $urandom;
         if ($urandom_range(0, 1) == 0) t[1:0] = 2'b00;
         cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 2) == 0), t, $urandom_range(0, 1) == 1);
      end
      waited = 0;
      while (exp_q.size() > 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      #2;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL drain pending=%0d want=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
